// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU codes, mux selects.
// Also holds the packed control word the FSM decodes each cycle.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_MADDR  = 5'd2,
        S_MRD    = 5'd3,
        S_MWB    = 5'd4,
        S_MWR    = 5'd5,
        S_R_EX   = 5'd6,
        S_R_WB   = 5'd7,
        S_BR     = 5'd8,
        S_JMP    = 5'd9,
        S_JAL_WB = 5'd10,
        S_JAL_J  = 5'd11,
        S_JR     = 5'd12,
        S_I_EX   = 5'd13,
        S_I_WB   = 5'd14,
        S_TRAP   = 5'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JR    = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_SLT  = 2'b11;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] ASB_REG   = 2'b00;
    localparam logic [1:0] ASB_FOUR  = 2'b01;
    localparam logic [1:0] ASB_IMM   = 2'b10;
    localparam logic [1:0] ASB_IMMSH = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic       alu_src_a;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle; master = controller, slave = datapath side.
// Counter signals exist only when MC_CTRL_PERF_EN is defined.
interface mc_ctrl_fsm_if #(
    parameter int OPW   = 6,
    parameter int FUNCW = 6
`ifdef MC_CTRL_PERF_EN
    , parameter int CNTW = 32
`endif
);
    logic [OPW-1:0]   opcode;
    logic [FUNCW-1:0] func;
    logic             zero_in;
    logic             zero_out;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_read;
    logic             mem_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             IorD;
    logic             ir_write;
    logic             alu_src_a;
    logic             mem_to_reg;
    logic             reg_write;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [1:0]       reg_dst;
    logic [2:0]       operation;
    logic             trap;
    logic [4:0]       state;
`ifdef MC_CTRL_PERF_EN
    logic [CNTW-1:0]  cyc_cnt;
    logic [CNTW-1:0]  instr_cnt;
`endif

    modport master (
        input  opcode, func, zero_in, mem_ready,
        output zero_out, mem_req, mem_read, mem_write, pc_write, pc_write_cond, IorD,
               ir_write, alu_src_a, mem_to_reg, reg_write, alu_src_b, pc_src, reg_dst,
               operation, trap, state
`ifdef MC_CTRL_PERF_EN
        , output cyc_cnt, instr_cnt
`endif
    );

    modport slave (
        output opcode, func, zero_in, mem_ready,
        input  zero_out, mem_req, mem_read, mem_write, pc_write, pc_write_cond, IorD,
               ir_write, alu_src_a, mem_to_reg, reg_write, alu_src_b, pc_src, reg_dst,
               operation, trap, state
`ifdef MC_CTRL_PERF_EN
        , input cyc_cnt, instr_cnt
`endif
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_controller.sv
// ALU operation decode from alu_op and the R-type func field; purely combinational.
module alu_controller
    import mc_ctrl_pkg::*;
#(
    parameter int FUNCW = 6
) (
    input  logic [1:0]       alu_op,
    input  logic [FUNCW-1:0] func,
    output logic [2:0]       operation
);
    always_comb begin
        operation = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: operation = ALU_ADD;
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_SLT: operation = ALU_SLT;
            ALUOP_FUNC: begin
                case (func)
                    FN_ADD:  operation = ALU_ADD;
                    FN_SUB:  operation = ALU_SUB;
                    FN_AND:  operation = ALU_AND;
                    FN_OR:   operation = ALU_OR;
                    FN_SLT:  operation = ALU_SLT;
                    default: operation = ALU_AND;
                endcase
            end
            default: operation = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS controller: one state per cycle, controls combinational from state; FETCH/MRD/MWR
// stall until mem_ready. Define MC_CTRL_PERF_EN to add cycle and retired-instruction counters.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW             = 6,
    parameter int FUNCW           = 6,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
`ifdef MC_CTRL_PERF_EN
    , parameter int CNTW          = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    state_e         ps_q, ps_d;
    logic [OPW-1:0] op_q;
    ctrl_t          ctrl, ctrl_g;
    logic [2:0]     alu_operation;

    always_comb begin
        ps_d = ps_q;
        case (ps_q)
            S_FETCH:  if (bus.mem_ready) ps_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_J:           ps_d = S_JMP;
                    OP_BEQ:         ps_d = S_BR;
                    OP_RTYPE:       ps_d = S_R_EX;
                    OP_LW, OP_SW:   ps_d = S_MADDR;
                    OP_JAL:         ps_d = S_JAL_WB;
                    OP_JR:          ps_d = S_JR;
                    OP_SLTI, OP_ADDI: ps_d = S_I_EX;
                    default:        ps_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MADDR:  ps_d = (op_q == OP_LW) ? S_MRD : S_MWR;
            S_MRD:    if (bus.mem_ready) ps_d = S_MWB;
            S_MWB:    ps_d = S_FETCH;
            S_MWR:    if (bus.mem_ready) ps_d = S_FETCH;
            S_R_EX:   ps_d = S_R_WB;
            S_R_WB:   ps_d = S_FETCH;
            S_BR:     ps_d = S_FETCH;
            S_JMP:    ps_d = S_FETCH;
            S_JAL_WB: ps_d = S_JAL_J;
            S_JAL_J:  ps_d = S_FETCH;
            S_JR:     ps_d = S_FETCH;
            S_I_EX:   ps_d = S_I_WB;
            S_I_WB:   ps_d = S_FETCH;
            S_TRAP:   ps_d = S_TRAP;
            default:  ps_d = S_FETCH;
        endcase
    end

    // The IR may change after DECODE, so the opcode is kept for MADDR and I_EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= S_FETCH;
            op_q <= '0;
        end else begin
            ps_q <= ps_d;
            if (ps_q == S_DECODE) op_q <= bus.opcode;
        end
    end

    always_comb begin
        ctrl = '0;
        case (ps_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ASB_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = ASB_IMMSH;
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
            end
            S_MRD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            // mem_write is held through the wait; the memory commits on the ready cycle.
            S_MWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_R_WB: begin
                ctrl.reg_dst   = REGDST_RD;
                ctrl.reg_write = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_BRANCH;
            end
            S_JMP, S_JAL_J: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            S_JAL_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RA;
            end
            S_JR: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_REG;
            end
            S_I_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.alu_op    = (op_q == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RT;
            end
            S_TRAP:  ctrl.trap = 1'b1;
            default: ctrl = '0;
        endcase
    end

    alu_controller #(.FUNCW(FUNCW)) u_alu_ctrl (
        .alu_op    (ctrl.alu_op),
        .func      (bus.func),
        .operation (alu_operation)
    );

    // Reset silences every output at once, including a pending memory write.
    assign ctrl_g = rst ? ctrl : '0;

    assign bus.zero_out      = bus.zero_in;
    assign bus.mem_req       = ctrl_g.mem_req;
    assign bus.mem_read      = ctrl_g.mem_read;
    assign bus.mem_write     = ctrl_g.mem_write;
    assign bus.pc_write      = ctrl_g.pc_write;
    assign bus.pc_write_cond = ctrl_g.pc_write_cond;
    assign bus.IorD          = ctrl_g.iord;
    assign bus.ir_write      = ctrl_g.ir_write;
    assign bus.alu_src_a     = ctrl_g.alu_src_a;
    assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
    assign bus.reg_write     = ctrl_g.reg_write;
    assign bus.alu_src_b     = ctrl_g.alu_src_b;
    assign bus.pc_src        = ctrl_g.pc_src;
    assign bus.reg_dst       = ctrl_g.reg_dst;
    assign bus.trap          = ctrl_g.trap;
    assign bus.operation     = rst ? alu_operation : 3'b000;
    assign bus.state         = rst ? ps_q : 5'd0;

`ifdef MC_CTRL_PERF_EN
    logic [CNTW-1:0] cyc_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (ps_q != S_TRAP) cyc_cnt_q <= cyc_cnt_q + CNTW'(1);
            if (ps_d == S_FETCH && ps_q != S_FETCH) instr_cnt_q <= instr_cnt_q + CNTW'(1);
        end
    end

    assign bus.cyc_cnt   = cyc_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multicycle MIPS control FSM; next generation of the multicycle controller.
- Adds a variable-latency memory handshake (mem_req/mem_ready), illegal-opcode trapping and a correct JR PC update.
- Sits between the instruction register fields and the multicycle datapath.
- Drives all datapath mux, enable and memory controls; ALU operation comes from the alu_controller instance.

Parameters:
- OPW, 6, opcode field width.
- FUNCW, 6, func field width.
- TRAP_ON_ILLEGAL, 1, 1 = undecoded opcode enters TRAP; 0 = treated as NOP, returns to FETCH.
- CNTW, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- opcode  in  OPW  instruction opcode.
- func  in  FUNCW  R-type function field.
- zero_in  in  1  ALU zero from datapath.
- zero_out  out  1  = zero_in, combinational passthrough.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_read, mem_write  out  1  access type; valid while mem_req=1.
- pc_write, pc_write_cond, IorD, ir_write, alu_src_a, mem_to_reg, reg_write  out  1  datapath controls.
- alu_src_b, pc_src, reg_dst  out  2  mux selects.
- operation  out  3  ALU operation from alu_controller.
- trap  out  1  sticky illegal-opcode flag.
- state  out  5  current state encoding, for debug.

Behaviour:
- rst=0: ps=FETCH asynchronously; every output 0 (gated by rst), including trap. zero_out still follows zero_in.
- Outputs are combinational from ps. In memory states, outputs are also qualified by mem_ready.
- Default for every output in every state is 0.
- FETCH: mem_req=1, mem_read=1, alu_src_b=01.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, next DECODE.
- DECODE: alu_src_b=11. Next state by opcode:
  - J -> JMP
  - BEQ -> BR
  - RTYPE -> R_EX
  - LW, SW -> MADDR
  - JAL -> JAL_WB
  - JR -> JR
  - SLTI, ADDI -> I_EX
  - else -> TRAP or FETCH, per TRAP_ON_ILLEGAL.
- MADDR: alu_src_a=1, alu_src_b=10. Next MRD if LW, else MWR.
- MRD: mem_req=1, mem_read=1, IorD=1. Holds until mem_ready, then next MWB.
- MWB: reg_write=1, mem_to_reg=1. Next FETCH.
- MWR: mem_req=1, mem_write=1, IorD=1. Holds until mem_ready, then next FETCH.
  - mem_write stays asserted for every wait cycle; the memory commits exactly once, on the ready cycle.
- R_EX: alu_src_a=1, alu_op=10. Next R_WB.
- R_WB: reg_dst=01, reg_write=1. Next FETCH.
- BR: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_src=10. Next FETCH.
- JMP: pc_write=1, pc_src=01. Next FETCH.
- JAL_WB: reg_write=1, reg_dst=10. Next JAL_J.
- JAL_J: pc_write=1, pc_src=01. Next FETCH.
- JR: pc_write=1, pc_src=11. Next FETCH.
- I_EX: alu_src_a=1, alu_src_b=10. alu_op=11 for SLTI, 00 for ADDI. Next I_WB.
  - opcode is sampled in DECODE and held in an internal register, because the IR may not be stable later.
- I_WB: reg_write=1, reg_dst=00. Next FETCH.
- TRAP: all datapath controls 0, trap=1.
  - Remains in TRAP until reset; no PC or register updates.
- mem_ready=1 outside a memory state is ignored.
- Reset mid-wait drops mem_req immediately (asynchronous); no write is committed.
- All undefined state encodings next-state to FETCH.
- The next-state case statement carries a full default.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[CNTW] and instr_cnt[CNTW], both reset to 0.
  - cyc_cnt increments every cycle while not in TRAP.
  - instr_cnt increments on each transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNTW.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (5-bit);
  - opcode constants J, JAL, SLTI, JR, ADDI, BEQ, RTYPE, LW, SW;
  - alu_op codes 00/01/10/11;
  - pc_src, reg_dst and alu_src_b select codes.
- Sub-module: the existing alu_controller(alu_op, func, operation), instantiated unchanged.

Test Plan:
- Reset, then LW (opcode 100011) with mem_ready low 3 cycles in FETCH and 2 in MRD:
  - ir_write and pc_write pulse exactly once, on the ready cycle.
  - State sequence FETCH(x4), DECODE, MADDR, MRD(x3), MWB, FETCH.
  - reg_write=1 with mem_to_reg=1 in MWB.
- SW with mem_ready low 4 cycles in MWR -> mem_write=1 for 5 cycles, FSM returns to FETCH on the ready cycle.
- BEQ with zero_in=1 -> in BR: pc_write_cond=1, pc_src=10, zero_out=1; 3-cycle instruction.
- JR (000110) -> JR state drives pc_write=1, pc_src=11; next FETCH.
- Opcode 111111:
  - TRAP_ON_ILLEGAL=1: trap=1 and stays set over 10 cycles; rst low clears it.
  - TRAP_ON_ILLEGAL=0: returns to FETCH, trap=0.
- With MC_CTRL_PERF_EN, run J, ADDI, R-type with mem_ready tied 1 -> instr_cnt=3, cyc_cnt=11 at the fourth FETCH.
